// File: rtl/fptd_rsc_encoder.sv
// 8-state LTE recursive systematic convolutional (RSC) constituent encoder.
// A K-bit frame enters one bit per cycle over valid/ready. The encoder then
// appends 3 tail symbols that drive the shift register back to the all-zero
// state. Every output symbol goes through a single-entry output slot that
// honours downstream backpressure.
`timescale 1ns/1ps
module fptd_rsc_encoder #(
    parameter int K  = 40,
    parameter int CW = $clog2(K + 1)
) (
    input  logic Clock,
    input  logic nReset,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_sys,
    output logic out_par,
    output logic out_tail,
    output logic out_last,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    // The counter value at which the K-th information bit is accepted.
    localparam logic [CW-1:0] LAST_CNT  = CW'(K - 1);
    // The tail counter value of the third, final tail step.
    localparam logic [1:0]    LAST_TAIL = 2'd2;

    // Feedback polynomial g0 = 1 + D^2 + D^3.
    function automatic logic rsc_feedback(input logic u, input logic s2, input logic s3);
        return u ^ s2 ^ s3;
    endfunction

    // Forward polynomial g1 = 1 + D + D^3, applied to the feedback bit.
    function automatic logic rsc_parity(input logic fb, input logic s1, input logic s3);
        return fb ^ s1 ^ s3;
    endfunction

    state_t          state_q, state_d;
    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            s3_q, s3_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      tcnt_q, tcnt_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sys_q, out_sys_d;
    logic            out_par_q, out_par_d;
    logic            out_tail_q, out_tail_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;

    logic            slot_free_s;
    logic            accept_s;
    logic            tail_step_s;
    logic            step_in_s;
    logic            fb_s;
    logic            par_s;

    // Handshake qualifiers: the slot can take a symbol when empty or being drained.
    always_comb begin
        slot_free_s = ~out_valid_q | out_ready;
        accept_s    = (state_q == ST_DATA) & in_valid & slot_free_s;
        tail_step_s = (state_q == ST_TAIL) & slot_free_s;
    end

    assign in_ready = (state_q == ST_DATA) & slot_free_s;

    // Trellis branch: in tail mode the input is chosen so the feedback bit becomes zero.
    always_comb begin
        if (state_q == ST_TAIL) begin
            step_in_s = s2_q ^ s3_q;
        end else begin
            step_in_s = in_bit;
        end
        fb_s  = rsc_feedback(step_in_s, s2_q, s3_q);
        par_s = rsc_parity(fb_s, s1_q, s3_q);
    end

    // FSM state register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Trellis, counters and output slot registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_q       <= '0;
            tcnt_q      <= 2'd0;
            out_valid_q <= 1'b0;
            out_sys_q   <= 1'b0;
            out_par_q   <= 1'b0;
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            out_valid_q <= out_valid_d;
            out_sys_q   <= out_sys_d;
            out_par_q   <= out_par_d;
            out_tail_q  <= out_tail_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: frame start, end of data, end of tail.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (accept_s && (cnt_q == LAST_CNT)) begin
                    state_d = ST_TAIL;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_TAIL: begin
                if (tail_step_s && (tcnt_q == LAST_TAIL)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Trellis and counter updates; everything freezes while the slot is blocked.
    always_comb begin
        s1_d   = s1_q;
        s2_d   = s2_q;
        s3_d   = s3_q;
        cnt_d  = cnt_q;
        tcnt_d = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s1_d  = 1'b0;
                    s2_d  = 1'b0;
                    s3_d  = 1'b0;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    s1_d  = fb_s;
                    s2_d  = s1_q;
                    s3_d  = s2_q;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        tcnt_d = 2'd0;
                    end else begin
                        tcnt_d = tcnt_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_TAIL: begin
                if (tail_step_s) begin
                    s1_d   = fb_s;
                    s2_d   = s1_q;
                    s3_d   = s2_q;
                    tcnt_d = tcnt_q + 2'd1;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            default: begin
                s1_d   = 1'b0;
                s2_d   = 1'b0;
                s3_d   = 1'b0;
                cnt_d  = '0;
                tcnt_d = 2'd0;
            end
        endcase
    end

    // Output slot: load a data or tail symbol, empty on consumption, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sys_d   = out_sys_q;
        out_par_d   = out_par_q;
        out_tail_d  = out_tail_q;
        out_last_d  = out_last_q;
        busy_d      = (state_d != ST_IDLE);
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_sys_d   = in_bit;
            out_par_d   = par_s;
            out_tail_d  = 1'b0;
            out_last_d  = 1'b0;
        end else if (tail_step_s) begin
            out_valid_d = 1'b1;
            out_sys_d   = step_in_s;
            out_par_d   = par_s;
            out_tail_d  = 1'b1;
            out_last_d  = (tcnt_q == LAST_TAIL);
        end else if (slot_free_s) begin
            out_valid_d = 1'b0;
            out_tail_d  = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sys   = out_sys_q;
    assign out_par   = out_par_q;
    assign out_tail  = out_tail_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fptd_rsc_encoder.sv
// Bench for the RSC encoder: one K=4 and one K=40 instance, randomized frames
// and backpressure, compared against a sequence-level model of the code.
`timescale 1ns/1ps
module tb_fptd_rsc_encoder;

    localparam int KA = 4;
    localparam int KB = 40;

    typedef struct {
        bit sys;
        bit par;
        bit tail;
        bit last;
        int cyc;
    } sym_t;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    logic st_drv[2], st_stray[2], st[2];
    logic iv[2], ib[2], orr[2];
    logic ir[2], ov[2], os[2], op[2], ot[2], ol[2], bz[2];
    bit   bp[2];
    bit   stray_en;

    assign st[0] = st_drv[0] | st_stray[0];
    assign st[1] = st_drv[1] | st_stray[1];

    fptd_rsc_encoder #(.K(KA)) u_dut_a (
        .Clock(clk), .nReset(nReset), .start(st[0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .in_bit(ib[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .out_sys(os[0]), .out_par(op[0]), .out_tail(ot[0]), .out_last(ol[0]),
        .busy(bz[0])
    );

    fptd_rsc_encoder #(.K(KB)) u_dut_b (
        .Clock(clk), .nReset(nReset), .start(st[1]), .in_valid(iv[1]),
        .in_ready(ir[1]), .in_bit(ib[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .out_sys(os[1]), .out_par(op[1]), .out_tail(ot[1]), .out_last(ol[1]),
        .busy(bz[1])
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   vcnt0 = 0;
    sym_t mq0[$], mq1[$];
    int   acq0[$], acq1[$];
    bit   hold_prev[2];
    logic [3:0] held[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output and acceptance monitors.
    always @(negedge clk) begin
        if (nReset) begin
            if (ov[0] && orr[0]) mq0.push_back('{os[0], op[0], ot[0], ol[0], cyc});
            if (ov[1] && orr[1]) mq1.push_back('{os[1], op[1], ot[1], ol[1], cyc});
            if (iv[0] && ir[0]) acq0.push_back(cyc);
            if (iv[1] && ir[1]) acq1.push_back(cyc);
            if (ov[0]) vcnt0 <= vcnt0 + 1;
        end
    end

    // Outputs must stay put while a symbol is blocked.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!nReset) begin
                hold_prev[d] <= 1'b0;
            end else begin
                if (hold_prev[d])
                    check_eq($sformatf("hold_stable_d%0d", d),
                             {27'd0, ov[d], os[d], op[d], ot[d], ol[d]},
                             {27'd0, 1'b1, held[d]});
                hold_prev[d] <= ov[d] && !orr[d];
                held[d]      <= {os[d], op[d], ot[d], ol[d]};
            end
        end
    end

    // Downstream ready: always 1 or random backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                orr[d] = bp[d] ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Stray start pulses while the K=4 encoder is busy.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            st_stray[0] = stray_en && bz[0] && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int qsize(input int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic sym_t qpop(input int d);
        if (d == 0) return mq0.pop_front();
        else return mq1.pop_front();
    endfunction

    task automatic pulse_start(input int d);
        int b = 0;
        do begin
            @(posedge clk);
            #1;
            b++;
        end while (bz[d] && b < 1000);
        if (bz[d]) check_eq("start_wait_idle", {31'd0, bz[d]}, 32'd0);
        st_drv[d] = 1'b1;
        @(posedge clk);
        #1;
        st_drv[d] = 1'b0;
    endtask

    task automatic send_bit(input int d, input bit b, input int gap);
        int  w = 0;
        bit  done = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        iv[d] = 1'b1;
        ib[d] = b;
        while (!done) begin
            @(negedge clk);
            if (ir[d]) begin
                done = 1'b1;
            end else begin
                w++;
                if (w > 1000) begin
                    check_eq("accept_wait", {31'd0, ir[d]}, 32'd1);
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic drive_frame(input int d, input bit u[$], input int glo, input int ghi);
        pulse_start(d);
        foreach (u[i]) send_bit(d, u[i], $urandom_range(ghi, glo));
    endtask

    // Reference: feedback sequence a_k = u_k ^ a_(k-2) ^ a_(k-3), parity
    // z_k = a_k ^ a_(k-1) ^ a_(k-3); tail inputs make a_k = 0.
    task automatic compare_frame(input int d, input bit u[$], input string tag, output sym_t g[$]);
        int n = u.size();
        int b = 0;
        bit a[$];
        bit am1, am2, am3, ai, es, ep, et, el;
        sym_t s;
        g = {};
        a = '{1'b0, 1'b0, 1'b0};
        while (qsize(d) < n + 3 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        check_eq({tag, "_count"}, (qsize(d) >= n + 3) ? n + 3 : qsize(d), n + 3);
        for (int i = 0; i < n + 3; i++) begin
            am1 = a[i + 2];
            am2 = a[i + 1];
            am3 = a[i];
            if (i < n) begin
                ai = u[i] ^ am2 ^ am3;
                es = u[i];
                ep = ai ^ am1 ^ am3;
                et = 1'b0;
                el = 1'b0;
            end else begin
                es = am2 ^ am3;
                ai = 1'b0;
                ep = am1 ^ am3;
                et = 1'b1;
                el = (i == n + 2);
            end
            a.push_back(ai);
            if (qsize(d) > 0) begin
                s = qpop(d);
                g.push_back(s);
                check_eq($sformatf("%s_sym%0d", tag, i),
                         {28'd0, s.sys, s.par, s.tail, s.last},
                         {28'd0, es, ep, et, el});
            end
        end
    endtask

    task automatic check_drained(input int d, input string tag);
        repeat (6) @(negedge clk);
        check_eq({tag, "_no_extra"}, qsize(d), 32'd0);
    endtask

    task automatic check_nogap(input sym_t g[$], input string tag);
        if (g.size() > 0)
            check_eq({tag, "_span"}, g[g.size() - 1].cyc - g[0].cyc, g.size() - 1);
    endtask

    bit   u[$], u2[$];
    sym_t g[$], g2[$];
    logic [6:0] sv, pv, tv, lv;
    int   a0, v0;

    initial begin
        nReset = 1'b0;
        stray_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st_drv[d] = 1'b0; st_stray[d] = 1'b0; iv[d] = 1'b0; ib[d] = 1'b0;
            orr[d] = 1'b1; bp[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            check_eq($sformatf("reset_outs_d%0d", d),
                     {25'd0, ir[d], ov[d], os[d], op[d], ot[d], ol[d], bz[d]}, 32'd0);
        nReset = 1'b1;

        // Frame 1011, no backpressure.
        u = '{1'b1, 1'b0, 1'b1, 1'b1};
        a0 = acq0.size();
        drive_frame(0, u, 0, 0);
        compare_frame(0, u, "t1", g);
        sv = '0; pv = '0; tv = '0; lv = '0;
        foreach (g[i]) begin
            sv = {sv[5:0], g[i].sys}; pv = {pv[5:0], g[i].par};
            tv = {tv[5:0], g[i].tail}; lv = {lv[5:0], g[i].last};
        end
        check_eq("t1_sys", sv, 7'b1011000);
        check_eq("t1_par", pv, 7'b1101000);
        check_eq("t1_tail", tv, 7'b0000111);
        check_eq("t1_last", lv, 7'b0000001);
        check_eq("t1_accepted", acq0.size() - a0, 32'd4);
        check_nogap(g, "t1");
        check_drained(0, "t1");
        check_eq("t1_busy_idle", {31'd0, bz[0]}, 32'd0);

        // Frame 1000: nonzero tail, final state zero.
        u = '{1'b1, 1'b0, 1'b0, 1'b0};
        drive_frame(0, u, 0, 0);
        compare_frame(0, u, "t2", g);
        sv = '0; pv = '0;
        foreach (g[i]) begin
            sv = {sv[5:0], g[i].sys}; pv = {pv[5:0], g[i].par};
        end
        check_eq("t2_sys", sv, 7'b1000101);
        check_eq("t2_par", pv, 7'b1111111);
        check_drained(0, "t2");
        check_eq("t2_final_state", {29'd0, u_dut_a.s1_q, u_dut_a.s2_q, u_dut_a.s3_q}, 32'd0);

        // K=40 random frame with random backpressure and input gaps.
        u = {};
        for (int i = 0; i < KB; i++) u.push_back(1'($urandom_range(0, 1)));
        bp[1] = 1'b1;
        a0 = acq1.size();
        drive_frame(1, u, 0, 2);
        compare_frame(1, u, "t3", g);
        check_drained(1, "t3");
        check_eq("t3_accepted", acq1.size() - a0, 32'd40);
        bp[1] = 1'b0;

        // Asynchronous reset after two bits, then a clean frame.
        pulse_start(0);
        send_bit(0, 1'b1, 0);
        send_bit(0, 1'b1, 0);
        #2;
        nReset = 1'b0;
        #1;
        check_eq("t4_reset_outs",
                 {25'd0, ir[0], ov[0], os[0], op[0], ot[0], ol[0], bz[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        nReset = 1'b1;
        mq0.delete();
        u = {};
        for (int i = 0; i < KA; i++) u.push_back(1'($urandom_range(0, 1)));
        drive_frame(0, u, 0, 0);
        compare_frame(0, u, "t4", g);
        check_drained(0, "t4");

        // Back-to-back frames with stray starts.
        u = {}; u2 = {};
        for (int i = 0; i < KA; i++) begin
            u.push_back(1'($urandom_range(0, 1)));
            u2.push_back(1'($urandom_range(0, 1)));
        end
        stray_en = 1'b1;
        drive_frame(0, u, 0, 0);
        drive_frame(0, u2, 0, 0);
        compare_frame(0, u, "t5a", g);
        compare_frame(0, u2, "t5b", g2);
        stray_en = 1'b0;
        check_nogap(g, "t5a");
        check_nogap(g2, "t5b");
        if (g.size() == 7 && g2.size() == 7)
            check_eq("t5_frame_gap", g2[0].cyc - g[6].cyc, 32'd2);
        check_drained(0, "t5");

        // Input gaps of 3 cycles.
        u = {};
        for (int i = 0; i < KA; i++) u.push_back(1'($urandom_range(0, 1)));
        a0 = acq0.size();
        v0 = vcnt0;
        drive_frame(0, u, 3, 3);
        compare_frame(0, u, "t6", g);
        check_drained(0, "t6");
        if (g.size() == 7 && acq0.size() - a0 == 4) begin
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("t6_data_lat%0d", i), g[i].cyc, acq0[a0 + i] + 1);
            for (int j = 0; j < 3; j++)
                check_eq($sformatf("t6_tail_lat%0d", j), g[4 + j].cyc, g[3].cyc + 1 + j);
        end else begin
            check_eq("t6_accepted", acq0.size() - a0, 32'd4);
        end
        check_eq("t6_valid_cycles", vcnt0 - v0, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
